// File: rtl/hp35_sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// hp35_sram_port_arbiter_if
//
// Purpose: bundles every signal that crosses the boundary of the port-0 SRAM
// arbiter. It carries three groups of signals:
//   - the Wishbone slave window,
//   - the logic-analyzer debug strobes,
//   - SRAM port 0 and the busy flag.
//
// Modports:
//   slave  - the arbiter. It takes requests and sram_dout0, and drives the
//            acknowledges, the read data and the SRAM controls.
//   master - everything around the arbiter: the bus master, the debug logic
//            and the SRAM macro.
//
// Signal summary:
//   wbs_cyc_i/stb_i/we_i  Wishbone cycle, strobe and write enable
//   wbs_sel_i [3:0]       byte enables
//   wbs_adr_i [31:0]      byte address
//   wbs_dat_i [31:0]      write data
//   wbs_ack_o             one-cycle acknowledge
//   wbs_dat_o [31:0]      read data
//   la_req                debug request (the rising edge triggers)
//   la_we, la_addr        debug write enable and word address
//   la_wdata, la_wmask    debug write data and byte mask
//   la_done               one-cycle debug completion pulse
//   la_rdata              debug read data
//   sram_csb0/web0        active-low chip select and write enable
//   sram_wmask0           SRAM byte mask
//   sram_addr0            SRAM word address
//   sram_din0             SRAM write data
//   sram_dout0            SRAM read data
//   busy                  high while the arbiter is not idle
// -----------------------------------------------------------------------------
interface hp35_sram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;

    logic          la_req;
    logic          la_we;
    logic [AW-1:0] la_addr;
    logic [DW-1:0] la_wdata;
    logic [3:0]    la_wmask;
    logic          la_done;
    logic [DW-1:0] la_rdata;

    logic          sram_csb0;
    logic          sram_web0;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    logic          busy;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  la_req, la_we, la_addr, la_wdata, la_wmask,
        output la_done, la_rdata,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_dout0,
        output busy
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output la_req, la_we, la_addr, la_wdata, la_wmask,
        input  la_done, la_rdata,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_dout0,
        input  busy
    );
endinterface

// File: rtl/hp35_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// hp35_sram_port_arbiter
//
// Purpose: shares read/write port 0 of the HP-35 microcode SRAM between two
// requesters:
//   - the Wishbone slave window, used for ROM loading and readback;
//   - the logic-analyzer debug strobes.
// At most one access is in flight at a time. Every output is a register.
//
// Ports:
//   wb_clk_i  single clock; also clocks SRAM port 0
//   wb_rst_i  synchronous active-high reset
//   bus       hp35_sram_port_arbiter_if.slave: the Wishbone, debug and
//             SRAM port-0 signals, plus busy
//
// Access sequence: IDLE -> ACCESS -> (CAPTURE, reads only) -> RESP -> IDLE.
//   - Wishbone write: ack two cycles after the strobe is sampled.
//   - Wishbone read:  ack three cycles after the strobe is sampled.
// -----------------------------------------------------------------------------
module hp35_sram_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          AW        = 8,
    parameter int          DW        = 32
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    hp35_sram_port_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t        r_state, w_state_next;

    // Request bookkeeping
    logic          r_la_req_q;
    logic          r_la_pend,       w_la_pend_next;
    logic          r_last_grant_la, w_last_grant_la_next;   // 1 = debug won last
    logic          r_wb_acked,      w_wb_acked_next;
    logic          r_req_we,        w_req_we_next;
    logic          r_req_la,        w_req_la_next;

    // Registered outputs
    logic          r_csb,       w_csb_next;
    logic          r_web,       w_web_next;
    logic [3:0]    r_wmask,     w_wmask_next;
    logic [AW-1:0] r_addr,      w_addr_next;
    logic [DW-1:0] r_din,       w_din_next;
    logic          r_ack,       w_ack_next;
    logic [31:0]   r_wb_dat,    w_wb_dat_next;
    logic          r_done,      w_done_next;
    logic [DW-1:0] r_la_rdata,  w_la_rdata_next;
    logic          r_busy;

    logic          w_wb_hit;
    logic          w_la_rise;
    logic          w_la_want;
    logic          w_grant_wb;
    logic          w_grant_la;
    logic          w_finish;

    // A strobe that has already been acknowledged must not start a second
    // access. This matters while the master is still releasing stb.
    assign w_wb_hit = bus.wbs_cyc_i & bus.wbs_stb_i & ~r_wb_acked &
                      (bus.wbs_adr_i[31:10] == BASE_ADDR[31:10]);

    // A fresh edge competes in the same cycle it is seen, so a debug access
    // has the same latency as a Wishbone access. If the edge is not granted
    // at once, it is held in la_pend.
    assign w_la_rise = bus.la_req & ~r_la_req_q;
    assign w_la_want = r_la_pend | w_la_rise;

    // Round-robin: under contention, the side that did not win last time wins.
    assign w_grant_wb = w_wb_hit  & (~w_la_want | r_last_grant_la);
    assign w_grant_la = w_la_want & (~w_wb_hit  | ~r_last_grant_la);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state         <= S_IDLE;
            r_la_req_q      <= 1'b1;    // a level held through reset is not an edge
            r_la_pend       <= 1'b0;
            r_last_grant_la <= 1'b1;
            r_wb_acked      <= 1'b0;
            r_req_we        <= 1'b0;
            r_req_la        <= 1'b0;
            r_csb           <= 1'b1;
            r_web           <= 1'b1;
            r_wmask         <= 4'h0;
            r_addr          <= '0;
            r_din           <= '0;
            r_ack           <= 1'b0;
            r_wb_dat        <= '0;
            r_done          <= 1'b0;
            r_la_rdata      <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_la_req_q      <= bus.la_req;
            r_la_pend       <= w_la_pend_next;
            r_last_grant_la <= w_last_grant_la_next;
            r_wb_acked      <= w_wb_acked_next;
            r_req_we        <= w_req_we_next;
            r_req_la        <= w_req_la_next;
            r_csb           <= w_csb_next;
            r_web           <= w_web_next;
            r_wmask         <= w_wmask_next;
            r_addr          <= w_addr_next;
            r_din           <= w_din_next;
            r_ack           <= w_ack_next;
            r_wb_dat        <= w_wb_dat_next;
            r_done          <= w_done_next;
            r_la_rdata      <= w_la_rdata_next;
            r_busy          <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_csb_next           = 1'b1;
        w_web_next           = 1'b1;
        w_wmask_next         = r_wmask;
        w_addr_next          = r_addr;
        w_din_next           = r_din;
        w_ack_next           = 1'b0;
        w_done_next          = 1'b0;
        w_wb_dat_next        = r_wb_dat;
        w_la_rdata_next      = r_la_rdata;
        w_req_we_next        = r_req_we;
        w_req_la_next        = r_req_la;
        w_last_grant_la_next = r_last_grant_la;
        w_la_pend_next       = w_la_want;
        w_wb_acked_next      = r_wb_acked & bus.wbs_cyc_i & bus.wbs_stb_i;
        w_finish             = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // The controls are loaded on the grant edge. ACCESS then
                // drives the SRAM with values that later changes on the
                // request inputs cannot disturb.
                if (w_grant_wb) begin
                    w_state_next         = S_ACCESS;
                    w_csb_next           = 1'b0;
                    w_web_next           = ~bus.wbs_we_i;
                    w_wmask_next         = bus.wbs_we_i ? bus.wbs_sel_i : 4'hF;
                    w_addr_next          = bus.wbs_adr_i[AW+1:2];
                    w_din_next           = bus.wbs_dat_i;
                    w_req_we_next        = bus.wbs_we_i;
                    w_req_la_next        = 1'b0;
                    w_last_grant_la_next = 1'b0;
                end else if (w_grant_la) begin
                    w_state_next         = S_ACCESS;
                    w_csb_next           = 1'b0;
                    w_web_next           = ~bus.la_we;
                    w_wmask_next         = bus.la_we ? bus.la_wmask : 4'hF;
                    w_addr_next          = bus.la_addr;
                    w_din_next           = bus.la_wdata;
                    w_req_we_next        = bus.la_we;
                    w_req_la_next        = 1'b1;
                    w_last_grant_la_next = 1'b1;
                    w_la_pend_next       = 1'b0;
                end
            end
            S_ACCESS: begin
                if (r_req_we) begin
                    w_state_next = S_RESP;
                    w_finish     = 1'b1;
                end else begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_req_la) begin
                    w_la_rdata_next = bus.sram_dout0;
                end else begin
                    w_wb_dat_next   = bus.sram_dout0;
                end
                w_state_next = S_RESP;
                w_finish     = 1'b1;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // The response pulse is registered on the edge that enters RESP, so
        // it is visible exactly while the FSM sits in RESP. A Wishbone master
        // that has dropped cyc by then gets no ack. The SRAM access has
        // completed regardless.
        if (w_finish) begin
            if (r_req_la) begin
                w_done_next = 1'b1;
            end else if (bus.wbs_cyc_i) begin
                w_ack_next      = 1'b1;
                w_wb_acked_next = 1'b1;
            end
        end
    end

    assign bus.sram_csb0   = r_csb;
    assign bus.sram_web0   = r_web;
    assign bus.sram_wmask0 = r_wmask;
    assign bus.sram_addr0  = r_addr;
    assign bus.sram_din0   = r_din;
    assign bus.wbs_ack_o   = r_ack;
    assign bus.wbs_dat_o   = r_wb_dat;
    assign bus.la_done     = r_done;
    assign bus.la_rdata    = r_la_rdata;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_hp35_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hp35_sram_port_arbiter
//
// Drives the Wishbone and debug sides of the arbiter and models the SRAM
// macro behind port 0.
//   - Stimulus tasks push the expected responses into per-requester queues.
//     The expected read data comes from an abstract reference memory.
//   - A negedge monitor pops a queue entry on every ack/done and compares it
//     against the DUT.
//   - The tasks also check latency, the SRAM address and the SRAM mask.
// -----------------------------------------------------------------------------
module tb_hp35_sram_port_arbiter;

    localparam logic [31:0] BASE = 32'h3000_0000;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hp35_sram_port_arbiter_if #(.AW(8), .DW(32)) bus ();

    hp35_sram_port_arbiter #(
        .BASE_ADDR (BASE),
        .AW        (8),
        .DW        (32)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    exp_t        wb_q[$];
    exp_t        la_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sram_reads = 0;
    logic [31:0] ref_mem  [256];
    logic [31:0] sram_mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // SRAM macro model: inputs sampled on the rising edge, read data valid
    // after the edge.
    always @(posedge clk) begin
        if (bus.sram_csb0 === 1'b0) begin
            if (bus.sram_web0 === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_wmask0[b])
                        sram_mem[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
            end else begin
                bus.sram_dout0 <= sram_mem[bus.sram_addr0];
                sram_reads     <= sram_reads + 1;
            end
        end
    end

    // Monitor: one scoreboard pop per response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.wbs_ack_o || bus.la_done)
                check("ack_done_overlap", 32'(bus.wbs_ack_o & bus.la_done), 32'd0);
            if (bus.wbs_ack_o) begin
                check("wb_ack_expected", 32'(wb_q.size() != 0), 32'd1);
                if (wb_q.size() != 0) begin
                    e = wb_q.pop_front();
                    if (e.is_read) check("wb_rdata", bus.wbs_dat_o, e.data);
                end
            end
            if (bus.la_done) begin
                check("la_done_expected", 32'(la_q.size() != 0), 32'd1);
                if (la_q.size() != 0) begin
                    e = la_q.pop_front();
                    if (e.is_read) check("la_rdata", bus.la_rdata, e.data);
                end
            end
        end
    end

    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                             input logic [31:0] dat, input bit hit, input string name);
        int lat;
        bit saw_acc;
        logic [7:0] obs_addr;
        logic [3:0] obs_mask;
        exp_t e;
        @(negedge clk);
        if (hit) begin
            e.is_read = !we;
            e.data    = ref_mem[adr[9:2]];
            if (we) ref_write(adr[9:2], dat, sel);
            wb_q.push_back(e);
        end
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
        lat = 0; saw_acc = 0; obs_addr = '0; obs_mask = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.sram_csb0 == 1'b0) begin
                saw_acc = 1; obs_addr = bus.sram_addr0; obs_mask = bus.sram_wmask0;
            end
            if (bus.wbs_ack_o) begin lat = k; break; end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        if (hit) begin
            check({name, "_latency"}, 32'(lat), we ? 32'd2 : 32'd3);
            check({name, "_addr"}, 32'(obs_addr), 32'(adr[9:2]));
            check({name, "_mask"}, 32'(obs_mask), we ? 32'(sel) : 32'hF);
        end else begin
            check({name, "_no_ack"}, 32'(lat), 32'd0);
            check({name, "_no_csb"}, 32'(saw_acc), 32'd0);
        end
    endtask

    task automatic la_access(input logic [7:0] a, input logic we, input logic [3:0] m,
                             input logic [31:0] dat, input string name);
        int lat;
        logic [7:0] obs_addr;
        logic [3:0] obs_mask;
        exp_t e;
        @(negedge clk);
        e.is_read = !we;
        e.data    = ref_mem[a];
        if (we) ref_write(a, dat, m);
        la_q.push_back(e);
        bus.la_we = we; bus.la_addr = a; bus.la_wdata = dat; bus.la_wmask = m;
        bus.la_req = 1'b1;
        lat = 0; obs_addr = '0; obs_mask = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.sram_csb0 == 1'b0) begin
                obs_addr = bus.sram_addr0; obs_mask = bus.sram_wmask0;
            end
            // Disturb the request inputs after the grant; the access in
            // flight must keep its latched values.
            if (k == 1) begin
                bus.la_addr = 8'($urandom); bus.la_wdata = $urandom; bus.la_wmask = 4'($urandom);
            end
            if (bus.la_done) begin lat = k; break; end
        end
        bus.la_req = 1'b0;
        check({name, "_latency"}, 32'(lat), we ? 32'd2 : 32'd3);
        check({name, "_addr"}, 32'(obs_addr), 32'(a));
        check({name, "_mask"}, 32'(obs_mask), we ? 32'(m) : 32'hF);
    endtask

    // Wishbone and debug reads raised in the same cycle. Wishbone wins when
    // debug was granted last. Debug is then served one full read later.
    task automatic contend(input logic [7:0] wa, input logic [7:0] da, input string name);
        int t_a, t_d;
        exp_t e;
        @(negedge clk);
        e.is_read = 1'b1;
        e.data = ref_mem[wa]; wb_q.push_back(e);
        e.data = ref_mem[da]; la_q.push_back(e);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE | {22'd0, wa, 2'b00};
        bus.la_we = 1'b0; bus.la_addr = da; bus.la_req = 1'b1;
        t_a = -1; t_d = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.wbs_ack_o && t_a < 0) begin
                t_a = k; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
            end
            if (bus.la_done && t_d < 0) begin
                t_d = k; bus.la_req = 1'b0;
            end
            if (t_a >= 0 && t_d >= 0) break;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.la_req = 1'b0;
        check({name, "_wb_first"}, 32'(t_a), 32'd3);
        check({name, "_la_second"}, 32'(t_d), 32'd7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cnt2, reads0;
        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; sram_mem[i] = '0; end
        bus.sram_dout0 = '0;
        bus.la_we = 1'b0; bus.la_addr = '0; bus.la_wdata = '0; bus.la_wmask = '0;

        // Reset with both requesters active.
        bus.la_req = 1'b1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE; bus.wbs_dat_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csb",    32'(bus.sram_csb0),   32'd1);
        check("rst_web",    32'(bus.sram_web0),   32'd1);
        check("rst_wmask",  32'(bus.sram_wmask0), 32'd0);
        check("rst_addr",   32'(bus.sram_addr0),  32'd0);
        check("rst_din",    bus.sram_din0,        32'd0);
        check("rst_ack",    32'(bus.wbs_ack_o),   32'd0);
        check("rst_wbdat",  bus.wbs_dat_o,        32'd0);
        check("rst_done",   32'(bus.la_done),     32'd0);
        check("rst_rdata",  bus.la_rdata,         32'd0);
        check("rst_busy",   32'(bus.busy),        32'd0);
        rst = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.la_done || bus.sram_csb0 == 1'b0) cnt++;
        end
        check("rst_held_la_req_no_trigger", 32'(cnt), 32'd0);
        bus.la_req = 1'b0;

        // Directed accesses.
        wb_access(BASE + 32'h3FC, 1'b1, 4'hF, 32'hDEADBEEF, 1, "wb_wr_top");
        wb_access(BASE + 32'h3FC, 1'b0, 4'hF, 32'h0, 1, "wb_rd_top");
        check("wb_rd_top_value", bus.wbs_dat_o, 32'hDEADBEEF);
        la_access(8'd5, 1'b1, 4'b0101, 32'h11223344, "la_wr_mask");
        la_access(8'd5, 1'b0, 4'hF, 32'h0, "la_rd_mask");
        check("la_rd_mask_value", bus.la_rdata, 32'h0022_0044);
        wb_access(32'h3000_0400, 1'b0, 4'hF, 32'h0, 0, "wb_miss");

        // Contention, twice.
        contend(8'hFF, 8'd5, "cont1");
        contend(8'd5, 8'hFF, "cont2");

        // Abort: cyc dropped during CAPTURE.
        @(negedge clk);
        reads0 = sram_reads;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h3FC;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.sram_csb0 == 1'b0) break;
        end
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (bus.wbs_ack_o) cnt++; end
        check("abort_no_ack", 32'(cnt), 32'd0);
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_read_done", 32'(sram_reads - reads0), 32'd1);

        // Reset during ACCESS.
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h10; bus.wbs_dat_i = 32'hCAFE0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.sram_csb0 == 1'b0) break;
        end
        rst = 1'b1; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("midrst_csb", 32'(bus.sram_csb0), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt2 = 0;
        repeat (5) begin @(negedge clk); if (bus.wbs_ack_o || bus.la_done) cnt2++; end
        check("midrst_no_ack", 32'(cnt2), 32'd0);
        // The interrupted write may or may not have reached the SRAM, so the
        // model forgets that word by overwriting it with a fresh write first.
        wb_access(BASE + 32'h10, 1'b1, 4'hF, 32'h0BAD_F00D, 1, "post_rst_wr");
        wb_access(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 1, "post_rst_rd");

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  m;
            sel = $urandom_range(0, 9);
            a   = 8'($urandom_range(0, 15));
            d   = $urandom;
            m   = 4'($urandom_range(0, 15));
            case (sel)
                0, 1, 2: wb_access(BASE | {22'd0, a, 2'b00}, 1'b1, m, d, 1, "rnd_wb_wr");
                3, 4:    wb_access(BASE | {22'd0, a, 2'b00}, 1'b0, 4'hF, 32'h0, 1, "rnd_wb_rd");
                5, 6:    la_access(a, 1'b1, m, d, "rnd_la_wr");
                7, 8:    la_access(a, 1'b0, 4'hF, 32'h0, "rnd_la_rd");
                default: wb_access(32'h3000_0800 | {22'd0, a, 2'b00}, 1'b1, 4'hF, d, 0, "rnd_wb_miss");
            endcase
        end

        repeat (4) @(negedge clk);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("la_queue_drained", 32'(la_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
